// File: rtl/timer_int_src.sv
// Machine timer: free-running counter with compare match that raises a W1C pending interrupt.
// Bus access completes in one cycle: ack_o and read data_o register on the edge after req_i.
// No backpressure: every request is accepted; back-to-back requests are acked every cycle.
module timer_int_src #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic [7:0]  int_flag_o
);

    localparam logic [1:0]  A_CTRL  = 2'd0;
    localparam logic [1:0]  A_COUNT = 2'd1;
    localparam logic [1:0]  A_VALUE = 2'd2;
    localparam logic [15:0] PMAX    = 16'(PRESCALE - 1);

    logic        en;
    logic        ie;
    logic        pend;
    logic [31:0] count;
    logic [31:0] value;
    logic [15:0] pcnt;

    logic        wr_ctrl;
    logic        wr_count;
    logic        wr_value;
    logic        tick;
    logic        hit;
    logic [32:0] count_inc;
    logic [31:0] rdata;
    logic        unused_addr;

    // Only word offsets 0..3 are decoded; upper and byte-lane bits are don't-care.
    assign unused_addr = ^{addr_i[31:4], addr_i[1:0]};

    assign wr_ctrl  = req_i & we_i & (addr_i[3:2] == A_CTRL);
    assign wr_count = req_i & we_i & (addr_i[3:2] == A_COUNT);
    assign wr_value = req_i & we_i & (addr_i[3:2] == A_VALUE);

    // en is the registered value, so a write disabling the timer still lets this cycle's tick land.
    assign tick      = en & (pcnt == PMAX);
    // 33-bit compare so COUNT = 0xFFFFFFFF cannot wrap past a nonzero VALUE.
    assign count_inc = {1'b0, count} + 33'd1;
    assign hit       = (value != 32'd0) && (count_inc >= {1'b0, value});

    // Interrupt comes straight from state, never from the bus inputs.
    assign int_flag_o = {7'b0, pend & ie};

    // Read mux over the register map; offset 3 reads as zero.
    always_comb begin
        rdata = 32'd0;
        case (addr_i[3:2])
            A_CTRL:  rdata = {29'd0, ie, pend, en};
            A_COUNT: rdata = count;
            A_VALUE: rdata = value;
            default: rdata = 32'd0;
        endcase
    end

    // Bus response: single-cycle ack, read data only in the ack cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_o  <= 1'b0;
            data_o <= 32'd0;
        end else begin
            ack_o  <= req_i;
            data_o <= (req_i && !we_i) ? rdata : 32'd0;
        end
    end

    // Prescaler: restarts from zero while disabled and whenever software rewrites COUNT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt <= 16'd0;
        end else if (!en || wr_count || tick) begin
            pcnt <= 16'd0;
        end else begin
            pcnt <= pcnt + 16'd1;
        end
    end

    // Counter: a software write beats the tick; a match reloads to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 32'd0;
        end else if (wr_count) begin
            count <= data_i;
        end else if (tick) begin
            count <= hit ? 32'd0 : count_inc[31:0];
        end
    end

    // Compare value; a tick in the same cycle still used the old value above.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= 32'd0;
        end else if (wr_value) begin
            value <= data_i;
        end
    end

    // Control bits; a match tick sets pend even if software clears it in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en   <= 1'b0;
            ie   <= 1'b0;
            pend <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en <= data_i[0];
                ie <= data_i[2];
            end
            if (tick && hit) begin
                pend <= 1'b1;
            end else if (wr_ctrl && data_i[1]) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_timer_int_src.sv
module tb_timer_int_src;

    typedef struct {
        int          due;
        bit          chk;
        logic [31:0] exp;
        string       name;
    } sb_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdat0, data0, addr1, wdat1, data1;
    logic        ack0, ack1;
    logic [7:0]  intf0, intf1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    sb_t q0[$];
    sb_t q1[$];
    vec_t vt[14];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    timer_int_src #(.PRESCALE(1)) dut (
        .clk(clk), .rst(rst), .req_i(req0), .we_i(we0), .addr_i(addr0), .data_i(wdat0),
        .data_o(data0), .ack_o(ack0), .int_flag_o(intf0)
    );

    timer_int_src #(.PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .req_i(req1), .we_i(we1), .addr_i(addr1), .data_i(wdat1),
        .data_o(data1), .ack_o(ack1), .int_flag_o(intf1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard side: pop an entry when its ack cycle arrives.
    task automatic mon(input int d, input logic a, input logic [31:0] dat);
        sb_t e;
        bit  due;
        if (d == 0) due = (q0.size() > 0) && (q0[0].due == cyc);
        else        due = (q1.size() > 0) && (q1[0].due == cyc);
        if (a || due) chk($sformatf("ack_o dut%0d", d), {31'b0, a}, {31'b0, due});
        if (due) begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            if (e.chk) chk(e.name, dat, e.exp);
            else       chk($sformatf("data_o on write dut%0d", d), dat, 32'd0);
        end else begin
            chk($sformatf("data_o idle dut%0d", d), dat, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mon(0, ack0, data0);
            mon(1, ack1, data1);
        end
    end

    // Drive one access in the current cycle and push what its ack cycle must show.
    task automatic access(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] e, input string nm);
        sb_t s;
        s.due  = cyc + 1;
        s.chk  = !w;
        s.exp  = e;
        s.name = nm;
        if (d == 0) begin
            req0 = 1'b1; we0 = w; addr0 = a; wdat0 = wd; q0.push_back(s);
        end else begin
            req1 = 1'b1; we1 = w; addr1 = a; wdat1 = wd; q1.push_back(s);
        end
        @(posedge clk); #1;
        req0 = 1'b0; we0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
    endtask

    task automatic wr(input int d, input logic [31:0] a, input logic [31:0] wd);
        access(d, 1'b1, a, wd, 32'd0, "write");
    endtask

    task automatic rd(input int d, input logic [31:0] a, input logic [31:0] e, input string nm);
        access(d, 1'b0, a, 32'd0, e, nm);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b0;
        req0 = 1'b0; we0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        chk({nm, " data_o"}, data0, 32'd0);
        chk({nm, " ack_o"}, {31'b0, ack0}, 32'd0);
        chk({nm, " int_flag_o"}, {24'b0, intf0}, 32'd0);
        chk({nm, " int_flag_o dut4"}, {24'b0, intf1}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vt[0]  = '{1'b0, 32'h0,  32'h0,        32'h0,        "ctrl after reset"};
        vt[1]  = '{1'b0, 32'h4,  32'h0,        32'h0,        "count after reset"};
        vt[2]  = '{1'b0, 32'h8,  32'h0,        32'h0,        "value after reset"};
        vt[3]  = '{1'b0, 32'hC,  32'h0,        32'h0,        "offset C after reset"};
        vt[4]  = '{1'b1, 32'h8,  32'h12345678, 32'h0,        "write value"};
        vt[5]  = '{1'b0, 32'h8,  32'h0,        32'h12345678, "value readback"};
        vt[6]  = '{1'b1, 32'h4,  32'hDEADBEEF, 32'h0,        "write count"};
        vt[7]  = '{1'b0, 32'h4,  32'h0,        32'hDEADBEEF, "count readback"};
        vt[8]  = '{1'b1, 32'hC,  32'hFFFFFFFF, 32'h0,        "write offset C"};
        vt[9]  = '{1'b0, 32'hC,  32'h0,        32'h0,        "offset C reads zero"};
        vt[10] = '{1'b1, 32'h0,  32'hFFFFFFFC, 32'h0,        "write ctrl ie only"};
        vt[11] = '{1'b0, 32'h0,  32'h0,        32'h4,        "ctrl readback"};
        vt[12] = '{1'b0, 32'h4,  32'h0,        32'hDEADBEEF, "count held while disabled"};
        vt[13] = '{1'b0, 32'h10, 32'h0,        32'h4,        "ctrl alias at 0x10"};

        rst = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; wdat0 = 32'd0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 32'd0; wdat1 = 32'd0;
        #1;
        chk("reset data_o", data0, 32'd0);
        chk("reset ack_o", {31'b0, ack0}, 32'd0);
        chk("reset int_flag_o", {24'b0, intf0}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Register map and readback, back-to-back.
        for (int i = 0; i < 14; i++)
            access(0, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp, vt[i].name);

        do_reset("reset2");

        // Basic period: VALUE = 5, enable with ie.
        wr(0, 32'h8, 32'd5);
        n = cyc;
        wr(0, 32'h0, 32'h5);
        for (int k = 1; k <= 7; k++) begin
            rd(0, 32'h4, (k <= 5) ? 32'(k - 1) : 32'(k - 6), $sformatf("basic count k=%0d", k));
            chk($sformatf("basic int_flag k=%0d", k), {24'b0, intf0}, (k >= 5) ? 32'h1 : 32'h0);
        end
        rd(0, 32'h0, 32'h7, "basic ctrl pending");

        // Clear colliding with match tick: set wins.
        wait_cyc(n + 10);
        wr(0, 32'h0, 32'h7);
        chk("w1c race int_flag", {24'b0, intf0}, 32'h1);
        wr(0, 32'h0, 32'h7);
        chk("w1c int_flag", {24'b0, intf0}, 32'h0);
        rd(0, 32'h0, 32'h5, "w1c ctrl en ie kept");

        // Masking: pend sets with ie = 0, then enabling ie raises the line.
        wr(0, 32'h0, 32'h3);
        wait_cyc(cyc + 6);
        rd(0, 32'h0, 32'h3, "masked ctrl pend");
        chk("masked int_flag", {24'b0, intf0}, 32'h0);
        wr(0, 32'h0, 32'h5);
        chk("unmask int_flag", {24'b0, intf0}, 32'h1);

        // VALUE = 0: free-run through wrap, no pend.
        wr(0, 32'h0, 32'h2);
        wr(0, 32'h8, 32'h0);
        wr(0, 32'h4, 32'hFFFFFFFE);
        wr(0, 32'h0, 32'h5);
        rd(0, 32'h4, 32'hFFFFFFFE, "wrap count 0");
        rd(0, 32'h4, 32'hFFFFFFFF, "wrap count 1");
        rd(0, 32'h4, 32'h0,        "wrap count 2");
        rd(0, 32'h4, 32'h1,        "wrap count 3");
        rd(0, 32'h0, 32'h5,        "wrap ctrl no pend");
        chk("wrap int_flag", {24'b0, intf0}, 32'h0);

        // VALUE lowered below COUNT: match on next tick.
        wr(0, 32'h0, 32'h6);
        wr(0, 32'h4, 32'd10);
        wr(0, 32'h8, 32'd4);
        wr(0, 32'h0, 32'h5);
        rd(0, 32'h4, 32'd10, "lowered count before tick");
        rd(0, 32'h4, 32'd0,  "lowered count after match");
        chk("lowered int_flag", {24'b0, intf0}, 32'h1);
        rd(0, 32'h0, 32'h7, "lowered ctrl");
        // COUNT write in a tick cycle wins.
        wr(0, 32'h4, 32'd100);
        rd(0, 32'h4, 32'd100, "count write vs tick");

        // Prescaler = 4 on the second instance.
        wr(1, 32'h8, 32'd3);
        n = cyc;
        wr(1, 32'h0, 32'h5);
        for (int k = 1; k <= 13; k++) begin
            rd(1, 32'h4, (k <= 4) ? 32'd0 : (k <= 8) ? 32'd1 : (k <= 12) ? 32'd2 : 32'd0,
               $sformatf("prescale count k=%0d", k));
            chk($sformatf("prescale int_flag k=%0d", k), {24'b0, intf1}, (k >= 12) ? 32'h1 : 32'h0);
        end
        wait_cyc(n + 18);
        wr(1, 32'h0, 32'h6);
        wait_cyc(n + 25);
        rd(1, 32'h4, 32'd1, "prescale frozen count");
        wr(1, 32'h0, 32'h5);
        for (int k = 27; k <= 31; k++)
            rd(1, 32'h4, (k == 31) ? 32'd2 : 32'd1, $sformatf("prescale restart k=%0d", k));

        // Reset mid-operation with an access in flight.
        wait_cyc(cyc + 3);
        chk("pre-reset int_flag", {24'b0, intf0}, 32'h1);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h4;
        @(posedge clk); #1;
        rst = 1'b0;
        req0 = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        chk("midreset ack_o", {31'b0, ack0}, 32'd0);
        chk("midreset data_o", data0, 32'd0);
        chk("midreset int_flag_o", {24'b0, intf0}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rd(0, 32'h0, 32'h0, "post-reset ctrl");
        rd(0, 32'h4, 32'h0, "post-reset count");
        rd(0, 32'h8, 32'h0, "post-reset value");

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
